// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and default constants for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned PC_STEP    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch controller bus: PC register loop, instruction memory port, decode port.
interface if_fetch_ctrl_if
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] pc_cur;
  logic [ADDR_W-1:0] npc;
  logic              pc_change;
  logic              pause;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              id_valid;
  logic [DATA_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic              id_ready;

  // Controller side
  modport master (
    input  pc_cur, redirect, redirect_pc, imem_ack, imem_rdata, id_ready,
    output npc, pc_change, pause, imem_req, imem_addr, id_valid, id_inst, id_pc
  );

  // Environment side (PC register, memory, decode)
  modport slave (
    output pc_cur, redirect, redirect_pc, imem_ack, imem_rdata, id_ready,
    input  npc, pc_change, pause, imem_req, imem_addr, id_valid, id_inst, id_pc
  );

endinterface

// File: rtl/if_fetch_ctrl_fetch_buf.sv
// Two-entry {pc, inst} FIFO between fetch and decode with synchronous flush.
module if_fetch_ctrl_fetch_buf
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_inst,
  output logic [1:0]        o_count,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_inst
);

  logic [ADDR_W-1:0] r_pc   [0:1];
  logic [DATA_W-1:0] r_inst [0:1];
  logic              r_rd;
  logic [1:0]        r_cnt;

  logic w_pop;
  logic w_wr_idx;

  // Flush wins over a same-cycle pop; write slot follows the head
  assign w_pop    = i_pop && (r_cnt != 2'd0) && !i_flush;
  assign w_wr_idx = r_rd ^ r_cnt[0];

  // Read pointer and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_pop) r_rd <= ~r_rd;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_pc[w_wr_idx]   <= i_pc;
      r_inst[w_wr_idx] <= i_inst;
    end
  end

  assign o_count = r_cnt;
  assign o_valid = (r_cnt != 2'd0);
  assign o_pc    = r_pc[r_rd];
  assign o_inst  = r_inst[r_rd];

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, PC feedback,
// two-entry buffer toward decode. Optional perf counters under FETCH_PERF_EN.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned PC_STEP = if_fetch_ctrl_pkg::PC_STEP
) (
  input  logic         clk,
  input  logic         rst,
`ifdef FETCH_PERF_EN
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt,
`endif
  if_fetch_ctrl_if.master bus
);

  fetch_state_e      r_state;
  logic              r_kill;
  logic [ADDR_W-1:0] r_req_addr;

  logic [1:0]        w_count;
  logic              w_id_valid;
  logic              w_ack_live;
  logic              w_push;
  logic              w_issue;
  logic              w_pc_change;
  logic [ADDR_W-1:0] w_npc;

  assign w_ack_live = (r_state == ST_WAIT) && bus.imem_ack;
  assign w_push     = w_ack_live && !r_kill && !bus.redirect;
  // A redirect in IDLE holds the issue one cycle so the stale pc_cur is never fetched
  assign w_issue    = (r_state == ST_IDLE) && (w_count != 2'd2) && !bus.redirect;

  // Request FSM with kill flag and latched request address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_kill     <= 1'b0;
      r_req_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state    <= ST_WAIT;
            r_req_addr <= bus.pc_cur;
          end
        end
        ST_WAIT: begin
          if (bus.imem_ack) begin
            r_state <= ST_IDLE;
            r_kill  <= 1'b0;
          end else if (bus.redirect) begin
            r_kill <= 1'b1;
          end
        end
      endcase
    end
  end

  // Next-PC selection: redirect target first, then sequential step on a live ack
  always_comb begin
    w_pc_change = 1'b0;
    w_npc       = '0;
    if (bus.redirect) begin
      w_pc_change = 1'b1;
      w_npc       = bus.redirect_pc;
    end else if (w_push) begin
      w_pc_change = 1'b1;
      w_npc       = r_req_addr + ADDR_W'(PC_STEP);
    end
  end

  assign bus.npc       = w_npc;
  assign bus.pc_change = w_pc_change;
  assign bus.pause     = (r_state == ST_IDLE) && (w_count == 2'd2) && !w_pc_change;
  assign bus.imem_req  = (r_state == ST_WAIT);
  assign bus.imem_addr = r_req_addr;
  assign bus.id_valid  = w_id_valid;

  if_fetch_ctrl_fetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fetch_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_id_valid && bus.id_ready),
    .i_flush (bus.redirect),
    .i_pc    (r_req_addr),
    .i_inst  (bus.imem_rdata),
    .o_count (w_count),
    .o_valid (w_id_valid),
    .o_pc    (bus.id_pc),
    .o_inst  (bus.id_inst)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Pushed-fetch and pause-cycle counters, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_push)    r_perf_fetch <= r_perf_fetch + 32'd1;
      if (bus.pause) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller that consumes the PC register output and closes the loop back to it. It drives next-PC, `pc_change` and `pause`, and issues one outstanding request at a time to instruction memory over a req/ack handshake. Fetched {pc, instruction} pairs are buffered in a 2-entry FIFO toward decode under valid/ready. It sits between the PC register, the instruction memory port and the ID stage.

Parameters:
- ADDR_W, 32, address / PC width
- DATA_W, 32, instruction width
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- pc_cur  input  ADDR_W  current PC from the PC register
- npc  output  ADDR_W  next PC toward the PC register
- pc_change  output  1  PC register load strobe
- pause  output  1  PC hold (fetch stalled)
- redirect  input  1  branch/jump taken, one-cycle pulse
- redirect_pc  input  ADDR_W  redirect target
- imem_req  output  1  memory request
- imem_addr  output  ADDR_W  request address
- imem_ack  input  1  data valid, one cycle
- imem_rdata  input  DATA_W  instruction data
- id_valid  output  1  buffer head valid
- id_inst  output  DATA_W  head instruction
- id_pc  output  ADDR_W  head PC
- id_ready  input  1  decode accepts head

Behaviour:
- Reset values: FSM in IDLE, FIFO count=0, kill=0, req_addr=0. Outputs: imem_req=0, id_valid=0, pc_change=0, pause=0, npc=0. Reset mid-request abandons the request immediately; memory must tolerate an abandoned request.
- FSM states are IDLE and WAIT.
  - IDLE → WAIT when count<2: latch req_addr=pc_cur.
  - IDLE with count==2: stay in IDLE, pause=1.
  - WAIT → IDLE on imem_ack.
- imem_req = (state==WAIT); imem_addr = req_addr. Both are stable until ack. Earliest ack is the first WAIT cycle, so peak throughput is 1 fetch per 2 cycles.
- Ack with kill=0:
  - push {req_addr, imem_rdata} into the FIFO;
  - pc_change=1 combinationally in the ack cycle;
  - npc = req_addr + PC_STEP, wrapping mod 2^ADDR_W.
- Redirect, in any state:
  - pc_change=1 and npc=redirect_pc in the same cycle;
  - FIFO flushed (count=0 next cycle); a same-cycle pop is ignored;
  - in WAIT without a same-cycle ack, set kill=1 and stay in WAIT.
- Ack with kill=1: data discarded, no pc_change, kill cleared, → IDLE.
- Redirect and ack in the same cycle: data discarded, npc=redirect_pc, kill stays 0, → IDLE.
- pause=0 whenever pc_change=1. pc_change is never asserted together with pause, so the PC register always loads on a pulse.
- FIFO:
  - id_valid = (count!=0); pop on id_valid&id_ready;
  - simultaneous push and pop keeps count unchanged and preserves order;
  - overflow is impossible: a request issues only at count<2 with a single request outstanding.
- A pop at count==2 makes count<2 next cycle, so a new request issues that cycle.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: two extra outputs, perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on every pushed (non-killed) ack.
  - perf_stall_cnt increments on every cycle with pause=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: no counters, no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package holds the FSM state typedef (IDLE, WAIT), PC_STEP, and the default ADDR_W/DATA_W constants.
- One sub-module, fetch_buf: 2-entry FIFO of {pc, inst} with push, pop, flush, count and head outputs.

Test Plan:
- Reset → pc_cur=0x0, ack 1 cycle after req:
  - imem_addr=0x0, pc_change pulse with npc=0x4;
  - id_valid with id_inst=rdata, id_pc=0x0;
  - next request at 0x4.
- id_ready=0, back-to-back acks:
  - two entries (pc 0x0, 0x4) buffered, then pause=1 with imem_req=0;
  - id_ready=1 pops in order 0x0 then 0x4, and fetch resumes.
- Redirect to 0x100 while in WAIT for 0x8, ack 3 cycles later:
  - pc_change with npc=0x100 immediately and FIFO flushed;
  - the late ack is discarded with no pc_change;
  - next request at 0x100.
- Redirect to 0x200 in the same cycle as ack for 0xC:
  - nothing pushed, npc=0x200;
  - next imem_addr=0x200.
- pc_cur=0xFFFFFFFC, ack → npc=0x00000000 (wrap).
- Assert rst while in WAIT:
  - imem_req drops immediately, id_valid=0, pause=0;
  - after release, the first request uses the current pc_cur.
